// File: rtl/seg_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment driver.
package seg_pkg;

  // Scan order: BLANK_2 -> SHOW_1 -> BLANK_1 -> SHOW_2 -> BLANK_2.
  typedef enum logic [1:0] {
    BLANK_2 = 2'd0,
    SHOW_1  = 2'd1,
    BLANK_1 = 2'd2,
    SHOW_2  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [1:0] AN_OFF    = 2'b11;
  localparam logic [1:0] AN_ONES   = 2'b10;
  localparam logic [1:0] AN_TENS   = 2'b01;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder, output order {g,f,e,d,c,b,a}.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Non-BCD codes show a dash so a bad upstream value is visible, not hidden.
  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0: o_seg = 7'b1000000;
      4'd1: o_seg = 7'b1111001;
      4'd2: o_seg = 7'b0100100;
      4'd3: o_seg = 7'b0110000;
      4'd4: o_seg = 7'b0011001;
      4'd5: o_seg = 7'b0010010;
      4'd6: o_seg = 7'b0000010;
      4'd7: o_seg = 7'b1111000;
      4'd8: o_seg = 7'b0000000;
      4'd9: o_seg = 7'b0010000;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_mux_2.sv
// Two-digit common-anode scan driver with per-frame digit snapshot and blanking gaps.
// Optional build macro SEG_MUX_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module seg_mux_2
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = $clog2(max_int(REFRESH_DIV, BLANK_CYCLES) + 1)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame,
  output state_t     dbg_state
);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_snap1;
  logic [3:0]       r_snap2;
  logic [6:0]       r_seg;
  logic [1:0]       r_an;
  logic             r_frame;

  logic             w_is_show;
  logic             w_last;
  logic             w_snap;
  logic [3:0]       w_snap1_nxt;
  logic [3:0]       w_snap2_nxt;
  logic [3:0]       w_dec_in;
  logic [6:0]       w_dec;
  logic [6:0]       w_seg_nxt;
  logic [1:0]       w_an_nxt;

  assign w_is_show = (r_state == SHOW_1) || (r_state == SHOW_2);
  assign w_last    = w_is_show ? (r_cnt == SHOW_LAST) : (r_cnt == BLANK_LAST);
  assign w_snap    = (r_state == BLANK_2) && w_last;

  // Values the snapshots will hold after this edge, so the output register
  // can show the freshly captured digit in the very first SHOW_1 cycle.
  assign w_snap1_nxt = w_snap ? digit_1 : r_snap1;
  assign w_snap2_nxt = w_snap ? digit_2 : r_snap2;

  always_comb begin
    w_next = r_state;
    if (w_last) begin
      case (r_state)
        BLANK_2: w_next = SHOW_1;
        SHOW_1:  w_next = BLANK_1;
        BLANK_1: w_next = SHOW_2;
        SHOW_2:  w_next = BLANK_2;
        default: w_next = BLANK_2;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= BLANK_2;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_snap1 <= 4'd0;
      r_snap2 <= 4'd0;
    end else if (w_snap) begin
      r_snap1 <= digit_1;
      r_snap2 <= digit_2;
    end
  end

  assign w_dec_in = (w_next == SHOW_2) ? w_snap2_nxt : w_snap1_nxt;

  bcd_to_seg u_dec (
    .i_bcd (w_dec_in),
    .o_seg (w_dec)
  );

  // Outputs are decoded from the next state so they flip on the same edge
  // as the state register and hold for the whole dwell.
  always_comb begin
    w_an_nxt  = AN_OFF;
    w_seg_nxt = SEG_BLANK;
    case (w_next)
      SHOW_1: begin
        w_an_nxt  = AN_ONES;
        w_seg_nxt = w_dec;
      end
      SHOW_2: begin
`ifdef SEG_MUX_LEADING_ZERO_BLANK_EN
        if (w_snap2_nxt != 4'd0) begin
          w_an_nxt  = AN_TENS;
          w_seg_nxt = w_dec;
        end
`else
        w_an_nxt  = AN_TENS;
        w_seg_nxt = w_dec;
`endif
      end
      default: begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_an    <= AN_OFF;
      r_seg   <= SEG_BLANK;
      r_frame <= 1'b0;
    end else begin
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
      r_frame <= w_snap;
    end
  end

  assign seg       = r_seg;
  assign an        = r_an;
  assign frame     = r_frame;
  assign dbg_state = r_state;

endmodule
